// File: rtl/core_seq.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, optional data-memory
// access and write-back, with acknowledge timeouts and a sticky trap state.
module core_seq #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 32,
  parameter int unsigned     TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  // instruction memory
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  // decoder side
  output logic [31:0]      instr,
  input  logic             dec_mem,
  input  logic             dec_memw,
  input  logic             dec_regw,
  input  logic             dec_pcsrc,
  input  logic             dec_illegal,
  input  logic [XLEN-1:0]  alu_result,
  // data memory
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  input  logic             dmem_ack,
  // status
  output logic             rf_we,
  output logic             retire,
  output logic             trap,
  output logic [XLEN-1:0]  pc,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam int unsigned     WAIT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  logic [2:0]        state_q,   state_d;
  logic [XLEN-1:0]   pc_q,      pc_d;
  logic [31:0]       instr_q,   instr_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic [WAIT_W-1:0] wait_q,    wait_d;
  logic [XLEN-1:0]   alu_q,     alu_d;
  logic              regw_q,    regw_d;
  logic              pcsrc_q,   pcsrc_d;
  logic              memw_q,    memw_d;

  logic [WAIT_W-1:0] wait_inc;
  logic              misalign;
  logic              wb_ok;

  assign wait_inc = wait_q + WAIT_W'(1);
  assign misalign = pcsrc_q && (alu_q[1:0] != 2'b00);
  assign wb_ok    = (state_q == S_WB) && !misalign;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    wait_d    = wait_q;
    alu_d     = alu_q;
    regw_d    = regw_q;
    pcsrc_d   = pcsrc_q;
    memw_d    = memw_q;

    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end else if (wait_inc == WAIT_MAX) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        alu_d   = alu_result;
        regw_d  = dec_regw;
        pcsrc_d = dec_pcsrc;
        memw_d  = dec_memw;
        if (dec_illegal) begin
          state_d = S_TRAP;
        end else if (dec_mem) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (wait_inc == WAIT_MAX) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_WB: begin
        // A misaligned branch target faults without committing pc or instret.
        if (misalign) begin
          state_d = S_TRAP;
        end else begin
          pc_d      = pcsrc_q ? alu_q : pc_q + XLEN'(4);
          instret_d = instret_q + CNT_W'(1);
          wait_d    = '0;
          state_d   = S_FETCH;
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      instret_q <= '0;
      wait_q    <= '0;
      alu_q     <= '0;
      regw_q    <= 1'b0;
      pcsrc_q   <= 1'b0;
      memw_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      wait_q    <= wait_d;
      alu_q     <= alu_d;
      regw_q    <= regw_d;
      pcsrc_q   <= pcsrc_d;
      memw_q    <= memw_d;
    end
  end

  // Gating with rst_n keeps the fetch request low for the whole reset window.
  assign imem_req  = rst_n && (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign dmem_req  = (state_q == S_MEM);
  assign dmem_we   = (state_q == S_MEM) && memw_q;
  assign dmem_addr = alu_q;
  assign rf_we     = wb_ok && regw_q;
  assign retire    = wb_ok;
  assign trap      = (state_q == S_TRAP);
  assign pc        = pc_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq: a per-instruction schedule model predicts
// every cycle's outputs, plus literal checks on retire timing, pc and traps.
module tb_core_seq;
  localparam int unsigned TO = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata, instr;
  logic        dec_mem, dec_memw, dec_regw, dec_pcsrc, dec_illegal;
  logic [31:0] alu_result;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr;
  logic        rf_we, retire, trap;
  logic [31:0] pc;
  logic [3:0]  instret;

  always #5 clk = ~clk;

  core_seq #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .dec_mem(dec_mem), .dec_memw(dec_memw), .dec_regw(dec_regw),
    .dec_pcsrc(dec_pcsrc), .dec_illegal(dec_illegal), .alu_result(alu_result),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .retire(retire), .trap(trap), .pc(pc), .instret(instret)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] alu;
    logic        regw;
    logic        pcsrc;
    logic        mem;
    logic        memw;
    logic        illegal;
  } ins_t;

  // architectural model
  logic [31:0] m_pc, m_instr;
  logic [3:0]  m_cnt;
  // expected control outputs for the current cycle
  logic        e_ireq, e_dreq, e_dwe, e_rfwe, e_ret, e_trap;
  logic [31:0] e_daddr;

  int unsigned n_tests = 0, n_fail = 0;
  int unsigned cyc_n = 0, last_ret = 0, dreq_cnt = 0;

  function automatic ins_t mk(input logic [31:0] rdata, input logic [31:0] alu,
                              input logic regw, input logic pcsrc, input logic mem,
                              input logic memw, input logic illegal);
    ins_t r;
    r.rdata = rdata; r.alu = alu; r.regw = regw; r.pcsrc = pcsrc;
    r.mem = mem; r.memw = memw; r.illegal = illegal;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    if (rst_n) begin
      cyc_n++;
      if (retire) last_ret = cyc_n;
      if (dmem_req) dreq_cnt++;
    end
    chk("imem_req", imem_req, e_ireq);
    if (e_ireq) chk("imem_addr", imem_addr, m_pc);
    chk("dmem_req", dmem_req, e_dreq);
    chk("dmem_we", dmem_we, e_dwe);
    if (e_dreq) chk("dmem_addr", dmem_addr, e_daddr);
    chk("rf_we", rf_we, e_rfwe);
    chk("retire", retire, e_ret);
    chk("trap", trap, e_trap);
    chk("pc", pc, m_pc);
    chk("instret", instret, m_cnt);
    chk("instr", instr, m_instr);
  endtask

  task automatic step();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic ireq, input logic dreq, input logic dwe,
                         input logic [31:0] daddr, input logic rfwe, input logic ret,
                         input logic trp);
    e_ireq = ireq; e_dreq = dreq; e_dwe = dwe; e_daddr = daddr;
    e_rfwe = rfwe; e_ret = ret; e_trap = trp;
  endtask

  // Out-of-window inputs are all driven active so that any stray sampling shows up.
  task automatic noise();
    imem_ack = 1'b1; dmem_ack = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    dec_mem = 1'b1; dec_memw = 1'b1; dec_regw = 1'b1; dec_pcsrc = 1'b1;
    dec_illegal = 1'b1; alu_result = 32'hDEAD_BEE1;
  endtask

  task automatic do_reset(input int unsigned n);
    rst_n = 1'b0;
    noise();
    m_pc = 32'h0; m_cnt = 4'h0; m_instr = 32'h0;
    set_exp(0, 0, 0, 32'h0, 0, 0, 0);
    repeat (n) step();
    cyc_n = 0; dreq_cnt = 0;
    rst_n = 1'b1;
  endtask

  task automatic trap_cycles(input int unsigned n);
    repeat (n) begin
      noise();
      set_exp(0, 0, 0, 32'h0, 0, 0, 1);
      step();
    end
  endtask

  // One instruction: wi imem wait cycles, wd dmem wait cycles; waits >= TO time out.
  // mem_cut != 0 stops after that many MEM cycles, leaving the DUT mid-access.
  task automatic run_instr(input ins_t i, input int unsigned wi, input int unsigned wd,
                           input int unsigned mem_cut);
    logic mis;
    for (int unsigned k = 0; k <= wi && k < TO; k++) begin
      noise();
      imem_ack   = (k == wi);
      imem_rdata = (k == wi) ? i.rdata : ~i.rdata;
      set_exp(1, 0, 0, 32'h0, 0, 0, 0);
      step();
    end
    if (wi >= TO) return;
    m_instr = i.rdata;
    noise();
    set_exp(0, 0, 0, 32'h0, 0, 0, 0);
    step();
    noise();
    dec_mem = i.mem; dec_memw = i.memw; dec_regw = i.regw;
    dec_pcsrc = i.pcsrc; dec_illegal = i.illegal; alu_result = i.alu;
    step();
    if (i.illegal) return;
    if (i.mem) begin
      for (int unsigned k = 0; k <= wd && k < TO; k++) begin
        if (mem_cut != 0 && k == mem_cut) return;
        noise();
        dmem_ack = (k == wd);
        set_exp(0, 1, i.memw, i.alu, 0, 0, 0);
        step();
      end
      if (wd >= TO) return;
    end
    mis = i.pcsrc && (i.alu[1:0] != 2'b00);
    noise();
    set_exp(0, 0, 0, 32'h0, i.regw && !mis, !mis, 0);
    step();
    if (!mis) begin
      m_pc  = i.pcsrc ? i.alu : m_pc + 32'd4;
      m_cnt = m_cnt + 4'd1;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    noise();
    set_exp(0, 0, 0, 32'h0, 0, 0, 0);
    m_pc = 32'h0; m_cnt = 4'h0; m_instr = 32'h0;
    #1;
    do_reset(3);

    // zero-wait ALU op straight out of reset
    run_instr(mk(32'h0000_0013, 32'h1234_5670, 1, 0, 0, 0, 0), 0, 0, 0);
    chk("alu_retire_cycle", last_ret, 4);
    chk("alu_pc", pc, 32'h4);
    chk("alu_instret", instret, 1);
    chk("alu_next_imem_addr", imem_addr, 32'h4);

    // 15 more sequential ops: 16 retirements wrap the 4-bit counter
    for (int unsigned n = 1; n < 16; n++) begin
      logic [31:0] nv;
      nv = n;
      run_instr(mk(32'h0000_0033 + nv, nv * 32'h11, nv[0], 0, 0, 0, 0), n % 3, 0, 0);
    end
    chk("cnt_wrap_instret", instret, 0);
    chk("cnt_wrap_pc", pc, 32'h40);

    // reset in the middle of a data access aborts at once
    run_instr(mk(32'h0000_3003, 32'h300, 1, 0, 1, 0, 0), 1, 10, 2);
    rst_n = 1'b0;
    #1;
    chk("midmem_dmem_req", dmem_req, 0);
    chk("midmem_retire", retire, 0);
    chk("midmem_rf_we", rf_we, 0);
    chk("midmem_pc", pc, 32'h0);
    do_reset(2);

    // load with three dmem wait cycles
    run_instr(mk(32'h0000_2003, 32'h100, 1, 0, 1, 0, 0), 0, 3, 0);
    chk("load_retire_cycle", last_ret, 8);
    chk("load_dreq_cycles", dreq_cnt, 4);
    chk("load_pc", pc, 32'h4);
    run_instr(mk(32'h0020_2023, 32'h204, 0, 0, 1, 1, 0), 2, 0, 0);
    run_instr(mk(32'h0000_0033, 32'h77, 1, 0, 0, 0, 0), TO - 1, 0, 0);
    chk("maxwait_pc", pc, 32'hC);
    run_instr(mk(32'h0000_0063, 32'h40, 0, 1, 0, 0, 0), 1, 0, 0);
    chk("branch_pc", pc, 32'h40);
    run_instr(mk(32'h0000_0063, 32'hFFFF_FFFC, 0, 1, 0, 0, 0), 0, 0, 0);
    run_instr(mk(32'h0000_0013, 32'h5, 1, 0, 0, 0, 0), 0, 0, 0);
    chk("pc_wrap", pc, 32'h0);
    run_instr(mk(32'h0000_0013, 32'h9, 1, 0, 0, 0, 0), 0, 0, 0);
    run_instr(mk(32'h0000_0063, 32'h42, 1, 1, 0, 0, 0), 0, 0, 0);
    trap_cycles(4);
    chk("misalign_trap", trap, 1);
    chk("misalign_pc", pc, 32'h4);
    chk("misalign_instret", instret, 7);

    // illegal opcode traps even when also flagged as a memory op
    do_reset(2);
    chk("post_reset_trap", trap, 0);
    run_instr(mk(32'hFFFF_FFFF, 32'h80, 1, 0, 1, 1, 1), 0, 0, 0);
    trap_cycles(6);
    chk("illegal_trap", trap, 1);
    chk("illegal_instret", instret, 0);
    chk("illegal_pc", pc, 32'h0);
    do_reset(2);
    chk("trap_cleared", trap, 0);
    run_instr(mk(32'h0000_0013, 32'h3, 1, 0, 0, 0, 0), 0, 0, 0);
    chk("recover_pc", pc, 32'h4);

    // reset during a fetch wait, then a fetch that never completes
    repeat (2) begin
      noise();
      imem_ack = 1'b0;
      set_exp(1, 0, 0, 32'h0, 0, 0, 0);
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("midfetch_imem_req", imem_req, 0);
    chk("midfetch_pc", pc, 32'h0);
    do_reset(2);
    run_instr(mk(32'h0000_0013, 32'h0, 1, 0, 0, 0, 0), 100, 0, 0);
    chk("ifetch_timeout_cycles", cyc_n, TO);
    chk("ifetch_timeout_trap", trap, 1);
    trap_cycles(3);

    // data access that never completes
    do_reset(2);
    run_instr(mk(32'h0000_2003, 32'h180, 1, 0, 1, 0, 0), 0, 100, 0);
    trap_cycles(2);
    chk("dmem_timeout_trap", trap, 1);
    chk("dmem_timeout_instret", instret, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
